// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths, state encoding and constants for the instruction-memory loader
package imem_loader_pkg;
  localparam int INSTR_W = 32;
  localparam int BYTE_W = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in and instruction-memory write port out
interface imem_loader_if;
  import imem_loader_pkg::*;
  logic [BYTE_W-1:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic mem_we;
  logic [31:0] mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  modport master (input byte_in, byte_valid, output byte_ready, mem_we, mem_addr, mem_wdata);
  modport slave (output byte_in, byte_valid, input byte_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: shifts bytes MSB-first into a word and flags the fourth byte
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [INSTR_W-1:0] word,
  output logic word_complete
);
  localparam int CW = $clog2(BYTES_PER_WORD);
  logic [CW-1:0] cnt;
  assign word_complete = en && cnt == CW'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word <= NOP;
      cnt <= '0;
    end else if (clr) begin
      word <= NOP;
      cnt <= '0;
    end else if (en) begin
      word <= {word[INSTR_W-BYTE_W-1:0], byte_in};
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into words and writes them to instruction memory while holding the CPU
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [CNT_W-1:0] num_words,
  imem_loader_if.master bus,
  output logic cpu_hold,
  output logic busy,
  output logic done,
  output logic err
);
  state_t state;
  logic [CNT_W-1:0] count, word_idx, nxt_idx;
  logic [INSTR_W-1:0] word;
  logic word_complete;
  logic take_start;
  assign take_start = start && (state == IDLE || state == DONE);
  assign nxt_idx = word_idx + 1'b1;
  assign bus.mem_wdata = word;
  imem_byte_packer u_pack (
    .clk(clk),
    .rst_n(rst_n),
    .clr(take_start),
    .en(bus.byte_valid && bus.byte_ready),
    .byte_in(bus.byte_in),
    .word(word),
    .word_complete(word_complete)
  );
  // byte_ready is a registered copy of (state == LOAD), so acceptance never depends on comb paths
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      word_idx <= '0;
      bus.byte_ready <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      cpu_hold <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          done <= 1'b0;
          err <= 1'b0;
          if (num_words == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else if (num_words > CNT_W'(DEPTH)) begin
            state <= DONE;
            done <= 1'b1;
            err <= 1'b1;
          end else begin
            state <= LOAD;
            count <= num_words;
            word_idx <= '0;
            bus.mem_addr <= '0;
            bus.byte_ready <= 1'b1;
            cpu_hold <= 1'b1;
            busy <= 1'b1;
          end
        end
        LOAD: if (word_complete) begin
          state <= WRITE;
          bus.byte_ready <= 1'b0;
          bus.mem_we <= 1'b1;
          bus.mem_addr <= 32'({word_idx, 2'b00});
        end
        WRITE: begin
          bus.mem_we <= 1'b0;
          word_idx <= nxt_idx;
          if (nxt_idx == count) begin
            state <= DONE;
            done <= 1'b1;
            cpu_hold <= 1'b0;
            busy <= 1'b0;
          end else begin
            state <= LOAD;
            bus.byte_ready <= 1'b1;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for the instruction-memory loader
module tb_imem_loader;
  localparam int DEPTH = 128;
  typedef struct {logic [31:0] a; logic [31:0] d;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] num_words = '0;
  logic cpu_hold, busy, done, err;
  imem_loader_if bus();
  imem_loader #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .bus(bus), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, n_push = 0, wcnt = 0, cyc = 0;
  int w_cyc[$];
  exp_t sb[$];
  logic [31:0] last_addr = '0;
  logic prev_we = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (!rst_n) prev_we = 1'b0;
    else begin
      if (bus.mem_we) begin
        exp_t e;
        wcnt++;
        w_cyc.push_back(cyc);
        last_addr = bus.mem_addr;
        chk("we_back_to_back", prev_we, 1'b0);
        chk("ready_in_write", bus.byte_ready, 1'b0);
        chk("addr_aligned", bus.mem_addr[1:0], 2'b00);
        chk("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_addr", bus.mem_addr, e.a);
          chk("wr_data", bus.mem_wdata, e.d);
        end
      end
      prev_we = bus.mem_we;
    end
  end
  task automatic push_words(input logic [7:0] b[$], input int nw);
    for (int i = 0; i < nw; i++) begin
      exp_t e;
      e.a = 32'(4 * i);
      e.d = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
      sb.push_back(e);
      n_push++;
    end
  endtask
  task automatic send_bytes(input logic [7:0] b[$], input int maxgap);
    foreach (b[i]) begin
      logic ok = 1'b0;
      int gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      if (gap > 0) begin
        bus.byte_valid = 1'b0;
        repeat (gap) tick();
      end
      bus.byte_in = b[i];
      bus.byte_valid = 1'b1;
      for (int k = 0; k < 64 && !ok; k++) begin
        ok = bus.byte_ready;
        tick();
      end
      if (!ok) chk("byte_accept_timeout", ok, 1'b1);
    end
    bus.byte_valid = 1'b0;
  endtask
  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    num_words = n;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_writes(input int target);
    for (int k = 0; k < 2000 && wcnt < target; k++) tick();
    chk("write_arrived", wcnt >= target, 1'b1);
  endtask
  task automatic wait_done();
    for (int k = 0; k < 2000 && !done; k++) tick();
    chk("done_seen", done, 1'b1);
  endtask
  initial begin
    logic [7:0] b[$];
    int base;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] b[$];
    int base;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    repeat (2) tick();
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_flags", {bus.byte_ready, cpu_hold, busy, done, err}, 0);
    rst_n = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in = 8'h5A;
    repeat (5) tick();
    chk("idle_ready", bus.byte_ready, 0);
    chk("idle_writes", wcnt, 0);
    // two words, start coinciding with the first valid byte
    b = '{8'h80, 8'h01, 8'h06, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
    push_words(b, 2);
    bus.byte_in = 8'h80;
    do_start(8'd2);
    chk("load_hold", {cpu_hold, busy, bus.byte_ready}, 3'b111);
    send_bytes(b, 0);
    wait_writes(2);
    chk("two_done", done, 1);
    chk("two_hold", cpu_hold, 0);
    chk("two_busy", busy, 0);
    chk("two_spacing", w_cyc[1] - w_cyc[0], 5);
    // stalled stream
    b = '{8'hA8, 8'h00, 8'hFF, 8'hFF};
    push_words(b, 1);
    do_start(8'd1);
    chk("restart_clears_done", done, 0);
    send_bytes(b, 3);
    wait_done();
    chk("stall_writes", wcnt, 3);
    // start edge cases
    do_start(8'd0);
    chk("zero_done", done, 1);
    chk("zero_err", err, 0);
    chk("zero_busy", busy, 0);
    do_start(8'(DEPTH + 1));
    chk("over_err", err, 1);
    chk("over_done", done, 1);
    chk("over_hold", cpu_hold, 0);
    // start while busy must not change the count
    b.delete();
    for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
    push_words(b, 3);
    do_start(8'd3);
    chk("accepted_clears_err", err, 0);
    send_bytes(b[0:4], 0);
    do_start(8'd1);
    chk("busy_start_ignored", busy, 1);
    send_bytes(b[5:11], 1);
    wait_done();
    chk("busy_writes", wcnt, 6);
    // reset mid-load after two bytes of the third word
    b.delete();
    for (int i = 0; i < 10; i++) b.push_back(8'($urandom));
    push_words(b, 2);
    base = wcnt;
    do_start(8'd3);
    send_bytes(b, 0);
    wait_writes(base + 2);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_hold", cpu_hold, 0);
    chk("mid_rst_flags", {bus.byte_ready, bus.mem_we, busy, done, err}, 0);
    chk("mid_rst_addr", bus.mem_addr, 0);
    chk("mid_rst_wdata", bus.mem_wdata, 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("no_third_write", wcnt, base + 2);
    b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_words(b, 1);
    do_start(8'd1);
    send_bytes(b, 0);
    wait_done();
    // full-depth load
    b.delete();
    for (int i = 0; i < 4 * DEPTH; i++) b.push_back(8'($urandom));
    push_words(b, DEPTH);
    do_start(8'(DEPTH));
    send_bytes(b, 0);
    wait_done();
    chk("depth_last_addr", last_addr, 32'(4 * (DEPTH - 1)));
    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    chk("total_writes", wcnt, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a byte stream, packs each group of four bytes into a 32-bit instruction word (MSB first), and writes the words into a writable instruction memory starting at byte address 0.
- Holds the CPU (cpu_hold) while a load is running, so the memory is written before any fetch starts.
- Sits between the host or UART byte source and the write port of the instruction memory.

Parameters:
- DEPTH, 128, capacity of the instruction memory in 32-bit words.
- CNT_W, 8, width of num_words and the internal word counter; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load of num_words words.
- num_words  in  CNT_W  word count, sampled on start.
- byte_in  in  8  incoming byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  out  32  byte address of the write; word-aligned, bits [1:0] always 0.
- mem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  high while a load is in progress.
- busy  out  1  state is LOAD or WRITE.
- done  out  1  load finished; held until the next accepted start.
- err  out  1  last start was rejected because num_words > DEPTH; held until the next accepted start.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs 0; mem_addr=0, mem_wdata=0.
  - Byte counter, word counter and shift register cleared.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE or DONE, start=1:
  - done and err are cleared.
  - num_words=0: go to DONE with no writes.
  - num_words>DEPTH: set err, go to DONE with no writes.
  - Otherwise: latch num_words, clear counters and address, go to LOAD.
- LOAD:
  - byte_ready=1, cpu_hold=1.
  - A byte is accepted when byte_valid & byte_ready.
  - Each accepted byte: shift = {shift[23:0], byte_in}; byte counter increments.
  - On the 4th accepted byte: byte counter wraps to 0, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_wdata=shift, mem_addr={word_idx, 2'b00} zero-extended to 32 bits.
  - byte_ready=0; byte_valid is ignored.
  - Next cycle: word_idx increments. If word_idx+1 == latched count, go to DONE; else go back to LOAD.
- DONE:
  - done=1, cpu_hold=0, byte_ready=0.
  - Stays in DONE until the next start.
- Latency and throughput:
  - mem_we is asserted in the cycle after the 4th byte is accepted.
  - Full-rate throughput is 5 cycles per word.
- Boundary conditions:
  - start while busy: ignored; no effect on counters.
  - byte_valid in IDLE, WRITE or DONE: ignored; no byte consumed.
  - Stalls in LOAD (byte_valid=0): partial word and counters are held indefinitely.
  - Last word lands at address 4*(count-1). Count=DEPTH is legal; the last address is 4*(DEPTH-1).
  - Reset mid-load: the partial word is discarded, mem_we is never asserted for it, and cpu_hold drops asynchronously.
  - start and byte_valid in the same IDLE cycle: the byte is not consumed; the first byte is taken in the first LOAD cycle.
- mem_we is asserted only in WRITE, never in two consecutive cycles, and never with a misaligned address.

Decomposition:
- Shared package:
  - State encoding constants (IDLE/LOAD/WRITE/DONE).
  - INSTR_W=32, BYTE_W=8, BYTES_PER_WORD=4.
  - NOP word constant 32'h00000000.
- Sub-module: imem_byte_packer, containing the shift register, 2-bit byte counter and word_complete flag.
- The FSM, word counter and address generation stay in imem_loader.

Test Plan:
- Reset state: rst_n=0 mid-stream → all outputs 0, state IDLE; release → no mem_we until start.
- Two-word load: start with num_words=2, bytes 80 01 06 0A 00 00 00 00 at full rate:
  - mem_we pulses with addr 0x0 / data 0x8001060A, then addr 0x4 / data 0x00000000.
  - Pulses are 5 cycles apart.
  - Next cycle after the last write: done=1, cpu_hold=0.
- Stalled bytes: num_words=1, bytes A8 00 FF FF with random byte_valid gaps:
  - Single write of data 0xA800FFFF to addr 0.
  - No byte is lost or duplicated; byte_ready=0 during WRITE.
- Start edge cases:
  - num_words=0 → done=1 next cycle, no writes.
  - num_words=DEPTH+1 → err=1, done=1, no writes.
  - num_words=DEPTH → last write at addr 4*(DEPTH-1).
- Reset mid-load: rst_n pulsed after 2 bytes of the 3rd word:
  - No third write occurs; all outputs return to 0.
  - A following start reloads from addr 0.
- start while busy: pulse start during LOAD → ignored; the original count completes unchanged.
